// File: rtl/wb_grf.sv
// Writeback stage and general register file: selects the writeback value, commits it,
// serves two D-stage read ports with write-through bypass and emits a commit trace.
module wb_grf #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemtoReg_W,
  input  logic             RegWrite_W,
  input  logic             Jal_W,
  input  logic [31:0]      PC_W,
  input  logic [31:0]      PC8_W,
  input  logic [31:0]      aluR_W,
  input  logic [31:0]      data_W,
  input  logic [4:0]       A3_W,
  input  logic [1:0]       Tnew_W,
  input  logic [4:0]       A1,
  input  logic [4:0]       A2,
  output logic [31:0]      RD1,
  output logic [31:0]      RD2,
  output logic [31:0]      WD_W,
  output logic             commit_valid,
  output logic [31:0]      commit_pc,
  output logic [4:0]       commit_reg,
  output logic [31:0]      commit_data,
  output logic [CNT_W-1:0] commit_cnt,
  output logic             tnew_err
);

  logic [31:0] regs [NREG];
  logic        we;
  logic        tnew_viol;

  always_comb begin
    if (Jal_W)           WD_W = PC8_W;
    else if (MemtoReg_W) WD_W = data_W;
    else                 WD_W = aluR_W;
  end

  // reset is active-low, so a high level means "not in reset"
  assign we        = RegWrite_W & (A3_W != '0) & (Tnew_W == '0) & reset;
  assign tnew_viol = RegWrite_W & (A3_W != '0) & (Tnew_W != '0);

  always_comb begin
    if (A1 == '0)                   RD1 = '0;
    else if (we && (A1 == A3_W))    RD1 = WD_W;
    else                            RD1 = regs[A1];
  end

  always_comb begin
    if (A2 == '0)                   RD2 = '0;
    else if (we && (A2 == A3_W))    RD2 = WD_W;
    else                            RD2 = regs[A2];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[A3_W] <= WD_W;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      commit_reg   <= '0;
      commit_data  <= '0;
      commit_cnt   <= '0;
      tnew_err     <= 1'b0;
    end else begin
      commit_valid <= we;
      if (we) begin
        commit_pc   <= PC_W;
        commit_reg  <= A3_W;
        commit_data <= WD_W;
        commit_cnt  <= commit_cnt + CNT_W'(1);
      end
      if (tnew_viol) tnew_err <= 1'b1;
    end
  end

endmodule
